// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel/line counters, blanking, delayed
// active-low syncs and frame-boundary outputs for renderers and game logic.
module vga_timing_gen #(
   parameter int H_VISIBLE  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_VISIBLE  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 1
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam logic [9:0] H_MAX        = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_MAX        = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic       frame_start_q;
   logic [7:0] frame_count_q, frame_count_d;
   logic       h_wrap, wrap;
   logic       hs_raw, vs_raw;

   assign h_wrap = (hc_q == H_MAX);
   assign wrap   = h_wrap && (vc_q == V_MAX);

   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latches.
      hc_d          = hc_q + 10'd1;
      vc_d          = vc_q;
      frame_count_d = frame_count_q;
      if (h_wrap) begin
         hc_d = '0;
         vc_d = (vc_q == V_MAX) ? 10'd0 : vc_q + 10'd1;
      end
      if (wrap) begin
         frame_count_d = frame_count_q + 8'd1;
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         hc_q          <= '0;
         vc_q          <= '0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         frame_start_q <= wrap;
         frame_count_q <= frame_count_d;
      end
   end

   assign hs_raw = !((hc_q >= H_SYNC_START) && (hc_q < H_SYNC_END));
   assign vs_raw = !((vc_q >= V_SYNC_START) && (vc_q < V_SYNC_END));

   // Syncs are delayed to line up with the renderers' registered RGB stage.
   if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs = hs_raw;
      assign vs = vs_raw;
   end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe_q;
      logic [SYNC_DELAY-1:0] vs_pipe_q;

      always_ff @(posedge vga_clk or posedge reset) begin
         if (reset) begin
            // Idle-high reset keeps a spurious sync pulse off the connector.
            hs_pipe_q <= '1;
            vs_pipe_q <= '1;
         end else begin
            hs_pipe_q[0] <= hs_raw;
            vs_pipe_q[0] <= vs_raw;
            for (int i = 1; i < SYNC_DELAY; i++) begin
               hs_pipe_q[i] <= hs_pipe_q[i-1];
               vs_pipe_q[i] <= vs_pipe_q[i-1];
            end
         end
      end

      assign hs = hs_pipe_q[SYNC_DELAY-1];
      assign vs = vs_pipe_q[SYNC_DELAY-1];
   end

   assign DrawX       = hc_q;
   assign DrawY       = vc_q;
   assign blank       = (hc_q < H_VIS) && (vc_q < V_VIS) && !reset;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size line timing (SYNC_DELAY 1 and 0)
// plus a shrunken-geometry instance for frame wrap, mid-frame reset and counter wrap.
module tb_vga_timing_gen;

   logic       vga_clk = 1'b0;
   logic       reset   = 1'b1;

   logic [9:0] x1, y1, x0, y0, xs, ys;
   logic       blank1, hs1, vs1, fs1;
   logic       blank0, hs0, vs0, fs0;
   logic       blank_s, hs_s, vs_s, fs_s;
   logic [7:0] fc1, fc0, fc_s;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   always #20 vga_clk = ~vga_clk;

   vga_timing_gen dut (
      .vga_clk(vga_clk), .reset(reset), .DrawX(x1), .DrawY(y1), .blank(blank1),
      .hs(hs1), .vs(vs1), .frame_start(fs1), .frame_count(fc1)
   );

   vga_timing_gen #(.SYNC_DELAY(0)) dut0 (
      .vga_clk(vga_clk), .reset(reset), .DrawX(x0), .DrawY(y0), .blank(blank0),
      .hs(hs0), .vs(vs0), .frame_start(fs0), .frame_count(fc0)
   );

   // 16 x 8 geometry: 128 clocks per frame, sync low on hc 10..12 and vc 5..6.
   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_DELAY(1)
   ) dut_s (
      .vga_clk(vga_clk), .reset(reset), .DrawX(xs), .DrawY(ys), .blank(blank_s),
      .hs(hs_s), .vs(vs_s), .frame_start(fs_s), .frame_count(fc_s)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   int   x, y, px;
   logic exp_b;
   int   pos_err, blank_err, hs_err, hs0_err, vs_err, fs1_cnt;
   int   hs_first_x, hs0_first_x, hs_low_cnt, hs0_low_cnt, blank_fall_x;
   int   y_at_799, x_at_800, y_at_800;
   int   fs_cnt, fs_bad, vs_lo0, vs_lo1, vs_first_x, vs_first_y;
   int   fc127, fc128, fc256, early_fs, fc_pre, fc_wrap, fs_wrap, pulses;

   initial begin
      pos_err = 0; blank_err = 0; hs_err = 0; hs0_err = 0; vs_err = 0; fs1_cnt = 0;
      hs_first_x = -1; hs0_first_x = -1; hs_low_cnt = 0; hs0_low_cnt = 0;
      blank_fall_x = -1; y_at_799 = -1; x_at_800 = -1; y_at_800 = -1;

      // Reset held 5 clocks
      repeat (5) @(posedge vga_clk);
      @(negedge vga_clk);
      check("rst_drawx", 32'(x1), 32'd0);
      check("rst_drawy", 32'(y1), 32'd0);
      check("rst_blank", 32'(blank1), 32'd0);
      check("rst_hs", 32'(hs1), 32'd1);
      check("rst_vs", 32'(vs1), 32'd1);
      check("rst_hs0", 32'(hs0), 32'd1);
      check("rst_frame_start", 32'(fs1), 32'd0);
      check("rst_frame_count", 32'(fc1), 32'd0);
      reset = 1'b0;
      #1;
      check("release_blank", 32'(blank1), 32'd1);
      check("release_drawx", 32'(x1), 32'd0);

      // Line sweep: n clocks after release, hc = n mod 800, vc = n / 800
      for (int n = 1; n <= 1700; n++) begin
         @(negedge vga_clk);
         x  = n % 800;
         y  = n / 800;
         px = (n - 1) % 800;
         if (int'(x1) != x || int'(y1) != y) pos_err++;
         exp_b = (x < 640) && (y < 480);
         if (blank1 !== exp_b) blank_err++;
         exp_b = !(px >= 656 && px < 752);
         if (hs1 !== exp_b) hs_err++;
         exp_b = !(x >= 656 && x < 752);
         if (hs0 !== exp_b) hs0_err++;
         if (vs1 !== 1'b1 || vs0 !== 1'b1) vs_err++;
         if (fs1 !== 1'b0) fs1_cnt++;
         if (hs1 === 1'b0 && hs_first_x < 0) hs_first_x = int'(x1);
         if (hs0 === 1'b0 && hs0_first_x < 0) hs0_first_x = int'(x0);
         if (n < 800 && hs1 === 1'b0) hs_low_cnt++;
         if (n < 800 && hs0 === 1'b0) hs0_low_cnt++;
         if (blank1 === 1'b0 && blank_fall_x < 0) blank_fall_x = int'(x1);
         if (n == 799) y_at_799 = int'(y1);
         if (n == 800) begin
            x_at_800 = int'(x1);
            y_at_800 = int'(y1);
         end
      end
      check("sweep_position", pos_err, 0);
      check("sweep_blank", blank_err, 0);
      check("sweep_hs_delay1", hs_err, 0);
      check("sweep_hs_delay0", hs0_err, 0);
      check("sweep_vs_idle", vs_err, 0);
      check("sweep_no_frame_start", fs1_cnt, 0);
      check("hs_first_low_x", hs_first_x, 657);
      check("hs_low_width", hs_low_cnt, 96);
      check("hs0_first_low_x", hs0_first_x, 656);
      check("hs0_low_width", hs0_low_cnt, 96);
      check("blank_fall_x", blank_fall_x, 640);
      check("drawy_before_wrap", y_at_799, 0);
      check("drawx_after_wrap", x_at_800, 0);
      check("drawy_after_wrap", y_at_800, 1);

      // Two frames on the small geometry from a fresh reset
      @(negedge vga_clk);
      reset = 1'b1;
      @(negedge vga_clk);
      @(negedge vga_clk);
      reset = 1'b0;
      #1;
      check("s_release_fs", 32'(fs_s), 32'd0);
      fs_cnt = 0; fs_bad = 0; vs_lo0 = 0; vs_lo1 = 0; vs_first_x = -1; vs_first_y = -1;
      fc127 = -1; fc128 = -1; fc256 = -1;
      for (int n = 1; n <= 260; n++) begin
         @(negedge vga_clk);
         if (fs_s === 1'b1) begin
            fs_cnt++;
            if (xs != 10'd0 || ys != 10'd0) fs_bad++;
         end
         if (vs_s === 1'b0) begin
            if (n <= 128) vs_lo0++;
            else if (n <= 256) vs_lo1++;
            if (vs_first_x < 0) begin
               vs_first_x = int'(xs);
               vs_first_y = int'(ys);
            end
         end
         if (n == 127) fc127 = int'(fc_s);
         if (n == 128) fc128 = int'(fc_s);
         if (n == 256) fc256 = int'(fc_s);
      end
      check("s_frame_start_pulses", fs_cnt, 2);
      check("s_frame_start_at_origin", fs_bad, 0);
      check("s_frame_count_0", fc127, 0);
      check("s_frame_count_1", fc128, 1);
      check("s_frame_count_2", fc256, 2);
      check("s_vs_low_frame0", vs_lo0, 32);
      check("s_vs_low_frame1", vs_lo1, 32);
      check("s_vs_first_y", vs_first_y, 5);
      check("s_vs_first_x", vs_first_x, 1);

      // Advance to (3,2) of the third frame, then reset between edges
      repeat (31) @(negedge vga_clk);
      check("s_pre_rst_drawx", 32'(xs), 32'd3);
      check("s_pre_rst_drawy", 32'(ys), 32'd2);
      check("s_pre_rst_blank", 32'(blank_s), 32'd1);
      check("s_pre_rst_count", 32'(fc_s), 32'd2);
      #5;
      reset = 1'b1;
      #1;
      check("s_async_drawx", 32'(xs), 32'd0);
      check("s_async_drawy", 32'(ys), 32'd0);
      check("s_async_blank", 32'(blank_s), 32'd0);
      check("s_async_count", 32'(fc_s), 32'd0);
      check("s_async_hs", 32'(hs_s), 32'd1);
      check("s_async_vs", 32'(vs_s), 32'd1);
      @(negedge vga_clk);
      reset = 1'b0;

      // 256 frames after release: count wraps 255 -> 0 on the 256th pulse
      early_fs = 0; fc_pre = -1; fc_wrap = -1; fs_wrap = -1; pulses = 0;
      for (int n = 1; n <= 32768; n++) begin
         @(negedge vga_clk);
         if (fs_s === 1'b1) pulses++;
         if (n < 128 && fs_s !== 1'b0) early_fs++;
         if (n == 1) check("s_restart_drawx", 32'(xs), 32'd1);
         if (n == 127) check("s_restart_count", 32'(fc_s), 32'd0);
         if (n == 32767) fc_pre = int'(fc_s);
         if (n == 32768) begin
            fc_wrap = int'(fc_s);
            fs_wrap = int'(fs_s);
         end
      end
      check("s_no_pulse_after_reset", early_fs, 0);
      check("s_pulses_256_frames", pulses, 256);
      check("s_count_before_wrap", fc_pre, 255);
      check("s_count_wrapped", fc_wrap, 0);
      check("s_pulse_at_wrap", fs_wrap, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
